if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Show-ahead instruction queue between instruction fetch and decode. It absorbs fetch packets (PC + instruction word) while decode is stalled, and presents the oldest entry to ID. It discards all wrong-path entries when the branch controller asserts its IF/ID invalidate. It consumes `if_id_instr_invalid_o` and `stallreg_from_id` from the control block and replaces the single-entry IF/ID register.

## Interface
- `DEPTH`, default 4: number of entries; must be a power of 2, ≥2.
- `ADDR_WIDTH`, default 32: PC width.
- `INSTR_WIDTH`, default 32: instruction word width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  wrong-path invalidate; driven by ctrl `if_id_instr_invalid_o`.
- `stall_i`  in  1  decode stall; driven by `stallreg_from_id`.
- `if_valid_i`  in  1  fetch packet present.
- `if_pc_i`  in  ADDR_WIDTH  fetch PC.
- `if_instr_i`  in  INSTR_WIDTH  fetched instruction.
- `if_ready_o`  out  1  buffer can accept a packet this cycle.
- `id_valid_o`  out  1  head entry is valid.
- `id_pc_o`  out  ADDR_WIDTH  head PC.
- `id_instr_o`  out  INSTR_WIDTH  head instruction.
- `count_o`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Circular buffer with `DEPTH` entries. Uses read pointer `rd_ptr`, write pointer `wr_ptr` (each $clog2(DEPTH) bits, wrap modulo DEPTH) and occupancy counter `count` (0..DEPTH).
- `if_ready_o = (count != DEPTH)`. It is purely a function of registered state: no dependence on `stall_i` or `flush_i`, and no full-with-pop pass-through.
- Push = `if_valid_i & if_ready_o & ~flush_i`. Writes `{if_pc_i, if_instr_i}` at `wr_ptr`; `wr_ptr` increments.
- Pop = `id_valid_o & ~stall_i`. `rd_ptr` increments.
- `id_valid_o = (count != 0)`. `id_pc_o`/`id_instr_o` show the entry at `rd_ptr` when valid. When empty they are forced to 0; instruction 0 is treated as a NOP by decode.
- Count update when not flushing: push only +1; pop only −1; both or neither unchanged.
- Flush (`flush_i = 1`):
  - Overrides push and stall.
  - The head entry presented in the flush cycle is the branch itself. It is deemed consumed by ID if `stall_i = 0`; ID latches it regardless.
  - Next cycle: `count = 0`, `rd_ptr = wr_ptr = 0`, `id_valid_o = 0`.
  - The incoming packet in the flush cycle is dropped. Entry contents need not be cleared.
- Back-to-back flush cycles (ctrl asserts for 2 cycles after a branch): each cycle leaves the buffer empty and drops input.
- Reset: `count = 0`, pointers 0, `if_ready_o = 1`, `id_valid_o = 0`, `id_pc_o = 0`, `id_instr_o = 0`, `count_o = 0`. Storage contents are don't-care.
- Reset asserted mid-operation: all entries are lost immediately (asynchronous). Outputs take reset values without waiting for an edge.

## Timing
- Write-to-read latency 1 cycle: a packet pushed at edge N appears on `id_*` after edge N. There is no combinational bypass from `if_*` to `id_*`.
- Full throughput: 1 push + 1 pop per cycle sustained.
- No combinational paths from the `if_*` inputs to `if_ready_o`. `stall_i`/`flush_i` affect only next-state logic.
- Full (`count = DEPTH`) with pop: `if_ready_o` stays 0 that cycle and becomes 1 the cycle after.
- Empty with push: `id_valid_o` is 1 next cycle.

## Structure
- A shared package holds `ADDR_WIDTH`/`INSTR_WIDTH` defaults, the `NOP_INSTR` constant (0) and the `if_packet_t` struct `{pc, instr}`.
- Single module. Storage is a register array of `if_packet_t`; no sub-module.

## Test plan
- **Reset then fill:** release `rst_n`, drive PCs 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c with `stall_i = 1` → `count_o` 1,2,3,4; `if_ready_o = 0` after the 4th push; `id_pc_o = 0x1c000000` throughout.
- **Drain:** from full, `stall_i = 0`, `if_valid_i = 0` → `id_pc_o` steps through …000, …004, …008, …00c on successive cycles, then `id_valid_o = 0`, `id_instr_o = 0`.
- **Streaming:** continuous push and pop → `count_o` stays 1 and each PC appears on `id_pc_o` exactly 1 cycle after its push.
- **Branch flush:** with 3 entries, assert `flush_i` for 2 cycles while `if_valid_i = 1` → `count_o = 0` after the first flush edge; no input is accepted in either flush cycle; the first post-flush push appears normally.
- **Full with simultaneous pop:** at `count = 4`, `stall_i = 0`, `if_valid_i = 1` → no push that cycle, `count_o = 3`, `if_ready_o = 1` the next cycle.
- **Async reset mid-stream:** drop `rst_n` between edges with 2 entries → `id_valid_o` and `count_o` go to 0 before the next `clk` edge.

Source files
------------

// File: rtl/if_id_buffer_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
package if_id_buffer_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 32;
  localparam int DEFAULT_INSTR_WIDTH = 32;

  // Decode treats an all-zero instruction word as a NOP.
  localparam logic [DEFAULT_INSTR_WIDTH-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [DEFAULT_ADDR_WIDTH-1:0]  pc;
    logic [DEFAULT_INSTR_WIDTH-1:0] instr;
  } if_packet_t;

endpackage : if_id_buffer_pkg

// File: rtl/if_id_buffer.sv
// Show-ahead instruction queue between fetch and decode; the oldest entry is
// always presented to ID, and a flush empties the queue in one cycle.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     stall_i,
  input  logic                     if_valid_i,
  input  logic [ADDR_WIDTH-1:0]    if_pc_i,
  input  logic [INSTR_WIDTH-1:0]   if_instr_i,
  output logic                     if_ready_o,
  output logic                     id_valid_o,
  output logic [ADDR_WIDTH-1:0]    id_pc_o,
  output logic [INSTR_WIDTH-1:0]   id_instr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Same layout as if_packet_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } packet_t;

  packet_t            mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;

  // Readiness and validity depend only on registered occupancy.
  assign if_ready_o = (count != CNT_W'(DEPTH));
  assign id_valid_o = (count != '0);
  assign count_o    = count;

  assign push = if_valid_i & if_ready_o & ~flush_i;
  assign pop  = id_valid_o & ~stall_i;

  assign id_pc_o    = id_valid_o ? mem[rd_ptr].pc    : '0;
  assign id_instr_o = id_valid_o ? mem[rd_ptr].instr : INSTR_WIDTH'(NOP_INSTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; occupancy and pointers
  // alone decide what is visible, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: if_pc_i, instr: if_instr_i};
  end

endmodule : if_id_buffer

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus a randomized
// run compared against a queue-based model of the buffer.
module tb_if_id_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic [31:0] if_instr_i = '0;
  logic        if_ready_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic [CW-1:0] count_o;

  int total = 0;
  int bad   = 0;

  // Reference model: the queue holds {pc, instr}, oldest at index 0.
  logic [63:0] q[$];

  if_id_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .stall_i(stall_i),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_instr_i(if_instr_i),
    .if_ready_o(if_ready_o), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_instr_o(id_instr_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] m_count();
    return CW'(q.size());
  endfunction
  function automatic logic m_valid();
    return q.size() != 0;
  endfunction
  function automatic logic m_ready();
    return q.size() != DEPTH;
  endfunction
  function automatic logic [31:0] m_pc();
    return (q.size() != 0) ? q[0][63:32] : 32'h0;
  endfunction
  function automatic logic [31:0] m_instr();
    return (q.size() != 0) ? q[0][31:0] : 32'h0;
  endfunction

  // Called at a falling edge: drive inputs, advance one rising edge, update
  // the model from the spec rules, return at the next falling edge.
  task automatic tick(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic st, input logic fl);
    bit do_push, do_pop;
    if_valid_i = v;
    if_pc_i    = pc;
    if_instr_i = ins;
    stall_i    = st;
    flush_i    = fl;
    do_push = v && (q.size() != DEPTH) && !fl;
    do_pop  = (q.size() != 0) && !st;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({pc, ins});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    total += 5;
    if (if_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", if_ready_o); end
    if (id_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", id_valid_o); end
    if (id_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", id_pc_o); end
    if (id_instr_o !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", id_instr_o); end
    if (count_o !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 32'h1c00_0000 + 32'(4 * i), 32'h0000_0013 + 32'(i << 8), 1'b1, 1'b0);
      total += 2;
      if (count_o !== CW'(i + 1)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count_o, i + 1); end
      if (id_pc_o !== 32'h1c00_0000) begin bad++; $display("FAIL fill_pc[%0d]: got %h want 1c000000", i, id_pc_o); end
    end
    total++;
    if (if_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready: got %b want 0", if_ready_o); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      total += 2;
      if (id_pc_o !== 32'h1c00_0000 + 32'(4 * i)) begin bad++; $display("FAIL drain_pc[%0d]: got %h want %h", i, id_pc_o, 32'h1c00_0000 + 32'(4 * i)); end
      if (id_instr_o !== 32'h0000_0013 + 32'(i << 8)) begin bad++; $display("FAIL drain_instr[%0d]: got %h", i, id_instr_o); end
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    total += 3;
    if (id_valid_o !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", id_valid_o); end
    if (id_instr_o !== 32'h0) begin bad++; $display("FAIL drain_instr_nop: got %h want 0", id_instr_o); end
    if (count_o !== '0) begin bad++; $display("FAIL drain_count: got %0d want 0", count_o); end
  endtask

  task automatic test_streaming();
    tick(1'b1, 32'h2000_0000, 32'hdead_0000, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      total += 2;
      if (count_o !== CW'(1)) begin bad++; $display("FAIL stream_count[%0d]: got %0d want 1", i, count_o); end
      if (id_pc_o !== 32'h2000_0000 + 32'(4 * (i - 1))) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, id_pc_o, 32'h2000_0000 + 32'(4 * (i - 1))); end
      tick(1'b1, 32'h2000_0000 + 32'(4 * i), 32'hdead_0000 + 32'(i), 1'b0, 1'b0);
    end
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    total++;
    if (id_valid_o !== 1'b0) begin bad++; $display("FAIL stream_end_valid: got %b want 0", id_valid_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h3000_0000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b1, 1'b0);
    total++;
    if (count_o !== CW'(3)) begin bad++; $display("FAIL flush_pre_count: got %0d want 3", count_o); end
    tick(1'b1, 32'h3000_0100, 32'h2222_0000, 1'b0, 1'b1);
    total += 2;
    if (count_o !== '0) begin bad++; $display("FAIL flush1_count: got %0d want 0", count_o); end
    if (id_valid_o !== 1'b0) begin bad++; $display("FAIL flush1_valid: got %b want 0", id_valid_o); end
    tick(1'b1, 32'h3000_0104, 32'h2222_0001, 1'b1, 1'b1);
    total += 3;
    if (count_o !== '0) begin bad++; $display("FAIL flush2_count: got %0d want 0", count_o); end
    if (id_valid_o !== 1'b0) begin bad++; $display("FAIL flush2_valid: got %b want 0", id_valid_o); end
    if (if_ready_o !== 1'b1) begin bad++; $display("FAIL flush2_ready: got %b want 1", if_ready_o); end
    tick(1'b1, 32'h4000_0000, 32'h3333_0000, 1'b1, 1'b0);
    total += 3;
    if (count_o !== CW'(1)) begin bad++; $display("FAIL post_flush_count: got %0d want 1", count_o); end
    if (id_pc_o !== 32'h4000_0000) begin bad++; $display("FAIL post_flush_pc: got %h want 40000000", id_pc_o); end
    if (id_instr_o !== 32'h3333_0000) begin bad++; $display("FAIL post_flush_instr: got %h want 33330000", id_instr_o); end
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h5000_0000 + 32'(4 * i), 32'h4444_0000 + 32'(i), 1'b1, 1'b0);
    total++;
    if (if_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", if_ready_o); end
    tick(1'b1, 32'h5000_00f0, 32'h4444_00f0, 1'b0, 1'b0);
    total += 3;
    if (count_o !== CW'(3)) begin bad++; $display("FAIL full_pop_count: got %0d want 3", count_o); end
    if (if_ready_o !== 1'b1) begin bad++; $display("FAIL full_pop_ready: got %b want 1", if_ready_o); end
    if (id_pc_o !== 32'h5000_0004) begin bad++; $display("FAIL full_pop_pc: got %h want 50000004", id_pc_o); end
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    total++;
    if (id_valid_o !== 1'b0) begin bad++; $display("FAIL full_pop_drained: got %b want 0", id_valid_o); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) tick(1'b1, 32'h6000_0000 + 32'(4 * i), 32'h5555_0000 + 32'(i), 1'b1, 1'b0);
    if_valid_i = 1'b0;
    total++;
    if (count_o !== CW'(2)) begin bad++; $display("FAIL areset_pre_count: got %0d want 2", count_o); end
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    total += 4;
    if (id_valid_o !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b want 0", id_valid_o); end
    if (count_o !== '0) begin bad++; $display("FAIL areset_count: got %0d want 0", count_o); end
    if (id_pc_o !== 32'h0) begin bad++; $display("FAIL areset_pc: got %h want 0", id_pc_o); end
    if (if_ready_o !== 1'b1) begin bad++; $display("FAIL areset_ready: got %b want 1", if_ready_o); end
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic v, st, fl;
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 15) == 0);
      tick(v, $urandom, $urandom, st, fl);
      total += 5;
      if (count_o !== m_count()) begin bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, count_o, m_count()); end
      if (id_valid_o !== m_valid()) begin bad++; $display("FAIL rand_valid[%0d]: got %b want %b", i, id_valid_o, m_valid()); end
      if (if_ready_o !== m_ready()) begin bad++; $display("FAIL rand_ready[%0d]: got %b want %b", i, if_ready_o, m_ready()); end
      if (id_pc_o !== m_pc()) begin bad++; $display("FAIL rand_pc[%0d]: got %h want %h", i, id_pc_o, m_pc()); end
      if (id_instr_o !== m_instr()) begin bad++; $display("FAIL rand_instr[%0d]: got %h want %h", i, id_instr_o, m_instr()); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_flush();
    test_full_pop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_id_buffer
